// File: rtl/gas_alarm_pkg.sv
// Shared definitions for the gas alarm controller: FSM state encoding,
// gas codes, pending-bit indices and the priority encoder.
package gas_alarm_pkg;

  localparam int unsigned NUM_GAS = 3;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALARM   = 2'd1;
  localparam logic [1:0] ST_SHUTOFF = 2'd2;
  localparam logic [1:0] ST_ACKED   = 2'd3;

  // gas_code output values
  localparam logic [1:0] GAS_NONE = 2'b00;
  localparam logic [1:0] GAS_CO   = 2'b01;
  localparam logic [1:0] GAS_CH4  = 2'b10;
  localparam logic [1:0] GAS_CO2  = 2'b11;

  // Bit positions inside a pending / acked mask
  localparam int unsigned IDX_CO  = 0;
  localparam int unsigned IDX_CH4 = 1;
  localparam int unsigned IDX_CO2 = 2;

  typedef logic [NUM_GAS-1:0] gas_mask_t;

  // Priority CO > methane > CO2
  function automatic logic [1:0] gas_encode(input gas_mask_t p);
    if (p[IDX_CO])       return GAS_CO;
    else if (p[IDX_CH4]) return GAS_CH4;
    else if (p[IDX_CO2]) return GAS_CO2;
    else                 return GAS_NONE;
  endfunction

endpackage

// File: rtl/gas_alarm_controller_filter.sv
// Confirm filter for one detector flag: the flag must be seen high for
// CONFIRM_CYC consecutive cycles before the sticky pending bit sets.
// Ports:
//   clk     - system clock, rising edge
//   arst    - synchronous active-high reset
//   din     - raw detector flag
//   clr     - clears the counter and the pending bit (wins over din)
//   pending - confirmed, sticky until clr or reset
module gas_confirm_filter #(
  parameter int unsigned CONFIRM_CYC = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic din,
  input  logic clr,
  output logic pending
);

  localparam int unsigned CNT_W = $clog2(CONFIRM_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_d;

  // Saturating run-length counter; pending sets on the edge the count reaches CONFIRM_CYC
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pending;
    if (clr) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (!din) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_W'(CONFIRM_CYC)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(CONFIRM_CYC - 1)) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q   <= '0;
      pending <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pending <= pend_d;
    end
  end

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: filters the three sticky detector flags, latches
// and prioritises pending alarms, and drives LED, buzzer and valve shutoff
// under an operator ack/clr handshake. Outputs decode registers only.
// Ports:
//   clk, arst            - clock, synchronous active-high reset
//   methane_det, co_det,
//   co2_det              - detector flags
//   ack, clr             - operator acknowledge / clear pulses
//   alarm_active         - ALARM, SHUTOFF or ACKED
//   buzzer               - ALARM or SHUTOFF
//   alarm_led            - blinking in ALARM, solid in SHUTOFF/ACKED
//   valve_close          - latched gas shutoff
//   gas_code             - highest-priority pending gas
module gas_alarm_controller
  import gas_alarm_pkg::*;
#(
  parameter int unsigned CONFIRM_CYC = 3,
  parameter int unsigned SHUTOFF_DLY = 8,
  parameter int unsigned BLINK_DIV   = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       methane_det,
  input  logic       co_det,
  input  logic       co2_det,
  input  logic       ack,
  input  logic       clr,
  output logic       alarm_active,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       valve_close,
  output logic [1:0] gas_code
);

  localparam int unsigned TMR_W = $clog2(SHUTOFF_DLY) + 1;
  localparam int unsigned BLK_W = $clog2(BLINK_DIV) + 1;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic             led_q, led_d;
  logic             valve_q, valve_d;
  gas_mask_t        mask_q, mask_d;
  gas_mask_t        pending;
  logic             filt_clr;

  // One confirm filter per gas; clr only reaches them when it is honoured
  gas_confirm_filter #(.CONFIRM_CYC(CONFIRM_CYC)) u_filt_co (
    .clk     (clk),
    .arst    (arst),
    .din     (co_det),
    .clr     (filt_clr),
    .pending (pending[IDX_CO])
  );

  gas_confirm_filter #(.CONFIRM_CYC(CONFIRM_CYC)) u_filt_ch4 (
    .clk     (clk),
    .arst    (arst),
    .din     (methane_det),
    .clr     (filt_clr),
    .pending (pending[IDX_CH4])
  );

  gas_confirm_filter #(.CONFIRM_CYC(CONFIRM_CYC)) u_filt_co2 (
    .clk     (clk),
    .arst    (arst),
    .din     (co2_det),
    .clr     (filt_clr),
    .pending (pending[IDX_CO2])
  );

  // Next-state logic for FSM, shutoff timer, blink divider, mask and valve latch
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    blink_d  = blink_q;
    led_d    = led_q;
    valve_d  = valve_q;
    mask_d   = mask_q;
    filt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          state_d = ST_ALARM;
          timer_d = '0;
          blink_d = '0;
          led_d   = 1'b1;
        end
      end
      ST_ALARM: begin
        if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
          blink_d = '0;
          led_d   = ~led_q;
        end else begin
          blink_d = blink_q + BLK_W'(1);
        end
        // ack beats timer expiry, so the valve stays open in that case
        if (ack) begin
          state_d = ST_ACKED;
          mask_d  = pending;
        end else if (timer_q == TMR_W'(SHUTOFF_DLY - 1)) begin
          state_d = ST_SHUTOFF;
          valve_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SHUTOFF: begin
        if (ack) begin
          state_d = ST_ACKED;
          mask_d  = pending;
        end
      end
      ST_ACKED: begin
        // clr beats a newly confirmed gas; it simply re-confirms afterwards
        if (clr) begin
          state_d  = ST_IDLE;
          mask_d   = '0;
          valve_d  = 1'b0;
          filt_clr = 1'b1;
        end else if (|(pending & ~mask_q)) begin
          state_d = ST_ALARM;
          timer_d = '0;
          blink_d = '0;
          led_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
      valve_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      valve_q <= valve_d;
      mask_q  <= mask_d;
    end
  end

  // Moore output decode
  assign alarm_active = (state_q != ST_IDLE);
  assign buzzer       = (state_q == ST_ALARM) || (state_q == ST_SHUTOFF);
  assign alarm_led    = (state_q == ST_ALARM) ? led_q
                                              : ((state_q == ST_SHUTOFF) || (state_q == ST_ACKED));
  assign valve_close  = valve_q;
  assign gas_code     = gas_encode(pending);

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed bench for gas_alarm_controller (CONFIRM_CYC=3, SHUTOFF_DLY=8, BLINK_DIV=4).
// Expected output word {alarm_active, buzzer, alarm_led, valve_close, gas_code[1:0]}
// is queued before each clock step and compared after it.
module tb_gas_alarm_controller;

  logic       clk;
  logic       arst;
  logic       methane_det, co_det, co2_det;
  logic       ack, clr;
  logic       alarm_active, buzzer, alarm_led, valve_close;
  logic [1:0] gas_code;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  string      tag_q[$];
  logic [5:0] exp_q[$];

  gas_alarm_controller #(
    .CONFIRM_CYC (3),
    .SHUTOFF_DLY (8),
    .BLINK_DIV   (4)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .methane_det  (methane_det),
    .co_det       (co_det),
    .co2_det      (co2_det),
    .ack          (ack),
    .clr          (clr),
    .alarm_active (alarm_active),
    .buzzer       (buzzer),
    .alarm_led    (alarm_led),
    .valve_close  (valve_close),
    .gas_code     (gas_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation, advance one edge, then pop and compare
  task automatic cyc(input string tag, input logic [5:0] e);
    string      t;
    logic [5:0] x;
    logic [5:0] o;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    tick();
    t = tag_q.pop_front();
    x = exp_q.pop_front();
    o = {alarm_active, buzzer, alarm_led, valve_close, gas_code};
    vectors++;
    assert (o === x) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", t, o, x);
    end
  endtask

  initial begin
    arst = 1'b1; methane_det = 1'b0; co_det = 1'b0; co2_det = 1'b0;
    ack = 1'b0; clr = 1'b0;

    // Reset
    tick();
    cyc("reset", 6'b000000);
    arst = 1'b0;

    // 1: two-cycle methane glitch never confirms; ack in IDLE is ignored
    methane_det = 1'b1; ack = 1'b1;
    cyc("t1_c1", 6'b000000);
    ack = 1'b0;
    cyc("t1_c2", 6'b000000);
    methane_det = 1'b0;
    repeat (20) cyc("t1_quiet", 6'b000000);

    // 2: CO alarm, blink pattern, valve shutoff, clr ignored, ack+clr, clear
    co_det = 1'b1;
    cyc("t2_c1", 6'b000000);
    cyc("t2_c2", 6'b000000);
    cyc("t2_c3_pending", 6'b000001);
    repeat (4) cyc("t2_alarm_led1", 6'b111001);
    repeat (4) cyc("t2_alarm_led0", 6'b110001);
    cyc("t2_shutoff", 6'b111101);
    clr = 1'b1;
    cyc("t2_clr_ignored", 6'b111101);
    clr = 1'b0;
    cyc("t2_shutoff_hold", 6'b111101);
    ack = 1'b1; clr = 1'b1;
    cyc("t2_ack_clr", 6'b101101);
    ack = 1'b0; clr = 1'b0; co_det = 1'b0;
    repeat (2) cyc("t2_acked_hold", 6'b101101);
    clr = 1'b1;
    cyc("t2_clr", 6'b000000);
    clr = 1'b0;
    repeat (2) cyc("t2_idle", 6'b000000);

    // 4: ack on the expiry cycle keeps the valve open; re-alarm after clr
    co_det = 1'b1;
    cyc("t4_c1", 6'b000000);
    cyc("t4_c2", 6'b000000);
    cyc("t4_c3", 6'b000001);
    repeat (4) cyc("t4_led1", 6'b111001);
    repeat (4) cyc("t4_led0", 6'b110001);
    ack = 1'b1;
    cyc("t4_ack_expiry", 6'b101001);
    ack = 1'b0;
    repeat (12) cyc("t4_valve_open", 6'b101001);
    clr = 1'b1;
    cyc("t4_clr", 6'b000000);
    clr = 1'b0;
    cyc("t4_reconf1", 6'b000000);
    cyc("t4_reconf2", 6'b000000);
    cyc("t4_reconf3", 6'b000001);
    cyc("t4_realarm", 6'b111001);
    ack = 1'b1;
    cyc("t4_ack", 6'b101001);
    ack = 1'b0; co_det = 1'b0; clr = 1'b1;
    cyc("t4_clr2", 6'b000000);
    clr = 1'b0;

    // 5: new gas while ACKED re-alarms; priority follows pending bits
    methane_det = 1'b1;
    cyc("t5_c1", 6'b000000);
    cyc("t5_c2", 6'b000000);
    cyc("t5_ch4_pending", 6'b000010);
    cyc("t5_alarm", 6'b111010);
    ack = 1'b1;
    cyc("t5_acked", 6'b101010);
    ack = 1'b0; co2_det = 1'b1;
    repeat (3) cyc("t5_co2_conf", 6'b101010);
    cyc("t5_realarm", 6'b111010);
    co_det = 1'b1;
    repeat (2) cyc("t5_co_conf", 6'b111010);
    cyc("t5_co_pending", 6'b111001);
    cyc("t5_led_off", 6'b110001);
    ack = 1'b1;
    cyc("t5_ack", 6'b101001);
    ack = 1'b0; methane_det = 1'b0; co_det = 1'b0; co2_det = 1'b0; clr = 1'b1;
    cyc("t5_clr", 6'b000000);
    clr = 1'b0;
    cyc("t5_idle", 6'b000000);

    // 6: reset during SHUTOFF with all detectors high
    methane_det = 1'b1; co_det = 1'b1; co2_det = 1'b1;
    cyc("t6_c1", 6'b000000);
    cyc("t6_c2", 6'b000000);
    cyc("t6_c3", 6'b000001);
    repeat (4) cyc("t6_led1", 6'b111001);
    repeat (4) cyc("t6_led0", 6'b110001);
    cyc("t6_shutoff", 6'b111101);
    arst = 1'b1;
    cyc("t6_arst", 6'b000000);
    arst = 1'b0;
    cyc("t6_r1", 6'b000000);
    cyc("t6_r2", 6'b000000);
    cyc("t6_r3", 6'b000001);
    cyc("t6_realarm", 6'b111001);

    // Scoreboard must be drained
    vectors++;
    assert (tag_q.size() === 0) else begin
      miscompares++;
      $error("FAIL sb_drain: observed %0d expected 0", tag_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gas_alarm_controller.md
Name: gas_alarm_controller

Overview:
Downstream consumer of the three serial gas-pattern detectors (methane, CO, CO2). Their sticky detect flags are filtered here, latched as pending alarms and prioritised. The block then drives a blinking LED, a buzzer and a gas-valve shutoff, using an operator ack/clear handshake. All outputs are Moore-decoded from registers; there is no combinational path from input to output.

Parameters:
CONFIRM_CYC, 3, consecutive high samples needed before a detect flag is accepted (>=1)
SHUTOFF_DLY, 8, cycles spent in ALARM without ack before the valve closes (>=1)
BLINK_DIV, 4, LED half-period in cycles while blinking (>=1)

Ports:
clk  input  1  system clock, rising edge
arst  input  1  reset; synchronous, active-high (name kept for codebase consistency; no asynchronous behaviour)
methane_det  input  1  methane detector flag (sticky upstream)
co_det  input  1  CO detector flag
co2_det  input  1  CO2 detector flag
ack  input  1  operator acknowledge, single-cycle pulse
clr  input  1  operator clear, single-cycle pulse
alarm_active  output  1  high in ALARM, SHUTOFF and ACKED
buzzer  output  1  high in ALARM and SHUTOFF
alarm_led  output  1  blinks in ALARM; solid 1 in SHUTOFF and ACKED
valve_close  output  1  latched gas shutoff
gas_code  output  2  highest-priority pending gas: 00 none, 01 CO, 10 methane, 11 CO2

Behaviour:
- Reset (arst high at a clock edge): FSM goes to IDLE. All counters, pending bits, acked_mask and valve latch clear. Every output reads 0 from that edge; arst takes priority over all other inputs.
- Confirm filter, one per gas:
  - A saturating counter increments each cycle the input is 1 and zeroes when the input is 0.
  - At the edge where the count reaches CONFIRM_CYC, the pending bit sets. It is sticky until clr.
  - A 1-cycle glitch shorter than CONFIRM_CYC never sets pending.
- Priority: CO > methane > CO2. gas_code always reflects the highest pending bit, in every state.
- FSM states IDLE, ALARM, SHUTOFF, ACKED:
  - IDLE: any pending bit -> ALARM. alarm_active rises CONFIRM_CYC+1 edges after the input first samples high.
  - ALARM:
    - Entry zeroes the shutoff timer and blink counter; alarm_led starts at 1.
    - The LED toggles every BLINK_DIV cycles.
    - ack -> ACKED, acked_mask <= pending.
    - Otherwise, at timer == SHUTOFF_DLY-1 -> SHUTOFF; the valve latch sets on that edge, so valve_close rises SHUTOFF_DLY cycles after ALARM entry.
    - ack on the expiry cycle wins: go to ACKED with the valve not closed.
  - SHUTOFF: buzzer 1, LED solid 1. ack -> ACKED, acked_mask <= pending; the valve stays closed.
  - ACKED:
    - buzzer 0, LED solid 1.
    - A pending bit not in acked_mask (a new gas) -> ALARM, timer restarts; an already-closed valve stays closed.
    - clr -> IDLE: clears pending, acked_mask, valve latch and all confirm counters.
    - Inputs still high re-confirm after CONFIRM_CYC cycles, because detectors are sticky. Re-alarm after clr is therefore the required behaviour.
- ack in IDLE or ACKED is ignored. clr outside ACKED is ignored.
- Simultaneous ack+clr in ALARM/SHUTOFF: ack acts, clr is ignored. Simultaneous new-gas and clr in ACKED: clr wins; the new gas re-confirms afterwards.
- Counter widths: $clog2(param)+1 bits. Counters never wrap; they saturate at the terminal value.

Decomposition:
- Shared package gas_alarm_pkg holds:
  - state encoding (IDLE=2'd0, ALARM=2'd1, SHUTOFF=2'd2, ACKED=2'd3);
  - gas code constants (GAS_NONE/GAS_CO/GAS_CH4/GAS_CO2);
  - pending-bit index constants (bit0 CO, bit1 methane, bit2 CO2).
- Sub-module gas_confirm_filter (params CONFIRM_CYC; ports clk, arst, din, clr, pending) is instantiated three times. FSM, timer, blink and priority encoder stay in the top.

Test Plan:
1. methane_det=1 for 2 cycles then 0 -> pending never sets; alarm_active and gas_code stay 0 for 20 cycles.
2. co_det=1 from cycle 0 -> alarm_active=1 and buzzer=1 at cycle 4, gas_code=01. alarm_led is 1 for cycles 4-7, 0 for 8-11, 1 from 12.
3. Continue 2 with no ack -> valve_close=1 at cycle 12. ack at cycle 15 -> buzzer 0, LED solid 1, valve stays 1. Drop co_det, clr at cycle 20 -> IDLE with all outputs 0.
4. ack asserted exactly on the timer-expiry cycle -> state ACKED, valve_close stays 0 indefinitely.
5. ACKED with methane pending; co2_det then confirms -> back to ALARM, buzzer 1, gas_code stays 10. Then co_det confirms -> gas_code 01.
6. arst pulse during SHUTOFF with all detect inputs held 1 -> all outputs 0 on the next edge. alarm_active re-asserts 4 cycles after arst drops, gas_code=01.
